// File: rtl/rc4_key_cracker_if.sv
// Handshake between the key-search controller and the RC4 test sequencer.
// The cracker side is the master: it launches tests and acknowledges verdicts.
interface rc4_key_cracker_if #(
  parameter int KEY_WIDTH = 24
);
  logic                 test_start;
  logic                 test_busy;
  logic                 test_message_valid;
  logic                 test_message_invalid;
  logic                 crack_ack;
  logic [KEY_WIDTH-1:0] key;

  modport master (
    output test_start, crack_ack, key,
    input  test_busy, test_message_valid, test_message_invalid
  );

  modport slave (
    input  test_start, crack_ack, key,
    output test_busy, test_message_valid, test_message_invalid
  );
endinterface

// File: rtl/rc4_key_cracker.sv
// Brute-force RC4 key-search controller: launches one sequencer test per key,
// acks each verdict and steps the key until found, exhausted or stopped.
module rc4_key_cracker #(
  parameter int                   KEY_WIDTH  = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_FIRST  = '0,
  parameter logic [KEY_WIDTH-1:0] KEY_LAST   = {2'b00, {(KEY_WIDTH-2){1'b1}}},
  parameter logic [KEY_WIDTH-1:0] KEY_STRIDE = {{(KEY_WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 start,
  input  logic                 stop,
  rc4_key_cracker_if.master    seq,
  output logic [KEY_WIDTH-1:0] keys_tried,
  output logic                 found,
  output logic                 exhausted,
  output logic                 busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_RESULT,
    S_ACK,
    S_RELEASE,
    S_NEXT,
    S_FOUND,
    S_EXHAUSTED
  } state_t;

  localparam logic [KEY_WIDTH-1:0] TRIED_ONE = {{(KEY_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q;
  logic [KEY_WIDTH-1:0] key_q;
  logic [KEY_WIDTH-1:0] keys_tried_q;
  logic                 verdict_valid_q;
  logic                 abort_q;
  logic                 test_start_q;
  logic                 crack_ack_q;
  logic                 found_q;
  logic                 exhausted_q;
  logic                 busy_q;

  // One extra bit so the stride can never wrap back into the legal range.
  logic [KEY_WIDTH:0]   key_sum_d;
  logic                 seq_idle;

  assign key_sum_d = {1'b0, key_q} + {1'b0, KEY_STRIDE};
  assign seq_idle  = !seq.test_busy && !seq.test_message_valid && !seq.test_message_invalid;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q         <= S_IDLE;
      key_q           <= KEY_FIRST;
      keys_tried_q    <= '0;
      verdict_valid_q <= 1'b0;
      abort_q         <= 1'b0;
      test_start_q    <= 1'b0;
      crack_ack_q     <= 1'b0;
      found_q         <= 1'b0;
      exhausted_q     <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      test_start_q <= 1'b0;
      crack_ack_q  <= 1'b0;

      // A test already in flight is drained; stop only suppresses the next launch.
      if (stop && (state_q inside {S_LAUNCH, S_WAIT_BUSY, S_WAIT_RESULT, S_ACK, S_RELEASE}))
        abort_q <= 1'b1;

      case (state_q)
        S_IDLE, S_FOUND, S_EXHAUSTED: begin
          if (start) begin
            key_q        <= KEY_FIRST;
            keys_tried_q <= '0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            abort_q      <= 1'b0;
            busy_q       <= 1'b1;
            test_start_q <= 1'b1;
            state_q      <= S_LAUNCH;
          end
        end
        S_LAUNCH: state_q <= S_WAIT_BUSY;
        S_WAIT_BUSY: begin
          if (seq.test_busy)
            state_q <= S_WAIT_RESULT;
        end
        S_WAIT_RESULT: begin
          if (seq.test_message_valid || seq.test_message_invalid) begin
            // A contradictory verdict (both high) counts as invalid.
            verdict_valid_q <= seq.test_message_valid && !seq.test_message_invalid;
            crack_ack_q     <= 1'b1;
            state_q         <= S_ACK;
          end
        end
        S_ACK: begin
          if (keys_tried_q != '1)
            keys_tried_q <= keys_tried_q + TRIED_ONE;
          state_q <= S_RELEASE;
        end
        S_RELEASE: begin
          if (seq_idle) begin
            if (verdict_valid_q) begin
              found_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_FOUND;
            end else if (abort_q || stop) begin
              exhausted_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= S_EXHAUSTED;
            end else begin
              state_q <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          if (stop || (key_sum_d > {1'b0, KEY_LAST})) begin
            exhausted_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_EXHAUSTED;
          end else begin
            key_q        <= key_sum_d[KEY_WIDTH-1:0];
            test_start_q <= 1'b1;
            state_q      <= S_LAUNCH;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign seq.test_start = test_start_q;
  assign seq.crack_ack  = crack_ack_q;
  assign seq.key        = key_q;
  assign keys_tried     = keys_tried_q;
  assign found          = found_q;
  assign exhausted      = exhausted_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_rc4_key_cracker.sv
// Directed bench: two crackers (stride 1 / stride 2) against small model
// sequencers that hold their verdict until acknowledged.
module tb_rc4_key_cracker;

  logic clk = 1'b0;
  logic nreset;
  logic start_a, stop_a, start_b, stop_b;
  logic [23:0] keys_tried_a, keys_tried_b;
  logic found_a, exhausted_a, busy_a;
  logic found_b, exhausted_b, busy_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rc4_key_cracker_if #(.KEY_WIDTH(24)) ifa ();
  rc4_key_cracker_if #(.KEY_WIDTH(24)) ifb ();

  rc4_key_cracker #(
    .KEY_WIDTH(24), .KEY_FIRST(24'h000000), .KEY_LAST(24'h000005), .KEY_STRIDE(24'h000001)
  ) dut_a (
    .clk(clk), .nreset(nreset), .start(start_a), .stop(stop_a), .seq(ifa.master),
    .keys_tried(keys_tried_a), .found(found_a), .exhausted(exhausted_a), .busy(busy_a)
  );

  rc4_key_cracker #(
    .KEY_WIDTH(24), .KEY_FIRST(24'h000001), .KEY_LAST(24'h000006), .KEY_STRIDE(24'h000002)
  ) dut_b (
    .clk(clk), .nreset(nreset), .start(start_b), .stop(stop_b), .seq(ifb.master),
    .keys_tried(keys_tried_b), .found(found_b), .exhausted(exhausted_b), .busy(busy_b)
  );

  // Model sequencer A: busy after start, verdict 3 cycles later, held until ack.
  logic [23:0] valid_key_a;
  logic        both_key0_a;
  logic [23:0] cur_key_a;
  logic        pend_a;
  int          lat_a;
  int          ack_cnt_a = 0;
  logic        overlap_a = 1'b0;
  logic [23:0] key_log_a[$];

  always @(posedge clk) begin
    if (!nreset) begin
      ifa.test_busy            <= 1'b0;
      ifa.test_message_valid   <= 1'b0;
      ifa.test_message_invalid <= 1'b0;
      pend_a                   <= 1'b0;
      lat_a                    <= 0;
    end else begin
      if (ifa.test_start) begin
        if (ifa.test_busy || ifa.test_message_valid || ifa.test_message_invalid)
          overlap_a <= 1'b1;
        key_log_a.push_back(ifa.key);
        cur_key_a     <= ifa.key;
        ifa.test_busy <= 1'b1;
        pend_a        <= 1'b1;
        lat_a         <= 3;
      end else if (pend_a) begin
        lat_a <= lat_a - 1;
        if (lat_a == 1) begin
          pend_a                   <= 1'b0;
          ifa.test_message_valid   <= (cur_key_a == valid_key_a);
          ifa.test_message_invalid <= (cur_key_a != valid_key_a) || (both_key0_a && cur_key_a == 24'h0);
        end
      end
      if (ifa.crack_ack) begin
        ifa.test_busy            <= 1'b0;
        ifa.test_message_valid   <= 1'b0;
        ifa.test_message_invalid <= 1'b0;
        ack_cnt_a                <= ack_cnt_a + 1;
      end
    end
  end

  // Model sequencer B: every key invalid, verdict 2 cycles after start.
  logic        pend_b;
  int          lat_b;
  logic [23:0] key_log_b[$];

  always @(posedge clk) begin
    if (!nreset) begin
      ifb.test_busy            <= 1'b0;
      ifb.test_message_valid   <= 1'b0;
      ifb.test_message_invalid <= 1'b0;
      pend_b                   <= 1'b0;
      lat_b                    <= 0;
    end else begin
      if (ifb.test_start) begin
        key_log_b.push_back(ifb.key);
        ifb.test_busy <= 1'b1;
        pend_b        <= 1'b1;
        lat_b         <= 2;
      end else if (pend_b) begin
        lat_b <= lat_b - 1;
        if (lat_b == 1) begin
          pend_b                   <= 1'b0;
          ifb.test_message_invalid <= 1'b1;
        end
      end
      if (ifb.crack_ack) begin
        ifb.test_busy            <= 1'b0;
        ifb.test_message_valid   <= 1'b0;
        ifb.test_message_invalid <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge; test_start and key must be valid the next cycle.
  task automatic start_a_pulse(input string tag);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check({tag, "_test_start"}, {31'b0, ifa.test_start}, 32'd1);
    check({tag, "_first_key"}, {8'b0, ifa.key}, 32'h0);
  endtask

  task automatic wait_idle_a(input string tag);
    int n = 0;
    while (busy_a === 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, {31'b0, (n >= 500)}, 32'd0);
  endtask

  task automatic wait_launch_a(input string tag, input int cnt);
    int n = 0;
    while (!(key_log_a.size() == cnt && ifa.test_busy === 1'b1 &&
             ifa.test_message_valid === 1'b0 && ifa.test_message_invalid === 1'b0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_launch_timeout"}, {31'b0, (n >= 500)}, 32'd0);
  endtask

  int log_base;
  int ack_base;

  initial begin
    nreset = 1'b0;
    start_a = 1'b0; stop_a = 1'b0; start_b = 1'b0; stop_b = 1'b0;
    valid_key_a = 24'hFFFFFF;
    both_key0_a = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_key", {8'b0, ifa.key}, 32'h0);
    check("rst_keys_tried", {8'b0, keys_tried_a}, 32'h0);
    check("rst_flags", {28'b0, found_a, exhausted_a, busy_a, ifa.test_start}, 32'h0);
    check("rst_ack", {31'b0, ifa.crack_ack}, 32'h0);
    check("rst_key_b", {8'b0, ifb.key}, 32'h1);
    nreset = 1'b1;
    @(negedge clk);

    // Stride 2 over 1..6: keys 1,3,5 then exhausted.
    log_base = key_log_b.size();
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("b_test_start", {31'b0, ifb.test_start}, 32'd1);
    check("b_first_key", {8'b0, ifb.key}, 32'h1);
    for (int n = 0; n < 500 && busy_b === 1'b1; n++) @(negedge clk);
    check("b_launches", key_log_b.size() - log_base, 32'd3);
    for (int i = 0; i < 3 && log_base + i < key_log_b.size(); i++)
      check($sformatf("b_key%0d", i), {8'b0, key_log_b[log_base + i]}, 32'(2 * i + 1));
    check("b_exhausted", {30'b0, found_b, exhausted_b}, 32'b01);
    check("b_final_key", {8'b0, ifb.key}, 32'h5);
    check("b_keys_tried", {8'b0, keys_tried_b}, 32'd3);
    $display("scenario stride2: launches=%0d key=%0h", key_log_b.size() - log_base, ifb.key);

    // All invalid: keys 0..5 in order, 6 acks, exhausted.
    log_base = key_log_a.size(); ack_base = ack_cnt_a;
    start_a_pulse("inv");
    wait_idle_a("inv");
    check("inv_launches", key_log_a.size() - log_base, 32'd6);
    for (int i = 0; i < 6 && log_base + i < key_log_a.size(); i++)
      check($sformatf("inv_key%0d", i), {8'b0, key_log_a[log_base + i]}, 32'(i));
    check("inv_acks", ack_cnt_a - ack_base, 32'd6);
    check("inv_flags", {30'b0, found_a, exhausted_a}, 32'b01);
    check("inv_keys_tried", {8'b0, keys_tried_a}, 32'd6);
    check("inv_final_key", {8'b0, ifa.key}, 32'h5);
    $display("scenario all_invalid: launches=%0d tried=%0d", key_log_a.size() - log_base, keys_tried_a);

    // Valid at key 3: found, key frozen, no relaunch.
    valid_key_a = 24'h000003;
    log_base = key_log_a.size(); ack_base = ack_cnt_a;
    start_a_pulse("val");
    wait_idle_a("val");
    repeat (10) @(negedge clk);
    check("val_flags", {30'b0, found_a, exhausted_a}, 32'b10);
    check("val_key", {8'b0, ifa.key}, 32'h3);
    check("val_keys_tried", {8'b0, keys_tried_a}, 32'd4);
    check("val_launches", key_log_a.size() - log_base, 32'd4);
    check("val_acks", ack_cnt_a - ack_base, 32'd4);
    $display("scenario valid_at_3: key=%0h tried=%0d", ifa.key, keys_tried_a);

    // Valid and invalid together on key 0 counts as invalid.
    valid_key_a = 24'h000000;
    both_key0_a = 1'b1;
    log_base = key_log_a.size();
    start_a_pulse("both");
    wait_idle_a("both");
    both_key0_a = 1'b0;
    check("both_launches", key_log_a.size() - log_base, 32'd6);
    if (key_log_a.size() > log_base + 1)
      check("both_second_key", {8'b0, key_log_a[log_base + 1]}, 32'h1);
    check("both_flags", {30'b0, found_a, exhausted_a}, 32'b01);
    $display("scenario both_verdicts: launches=%0d", key_log_a.size() - log_base);

    // Stop during key 2 test, invalid verdict: drained, then exhausted.
    valid_key_a = 24'hFFFFFF;
    log_base = key_log_a.size(); ack_base = ack_cnt_a;
    start_a_pulse("stopi");
    wait_launch_a("stopi", log_base + 3);
    stop_a = 1'b1;
    repeat (2) @(negedge clk);
    stop_a = 1'b0;
    wait_idle_a("stopi");
    repeat (5) @(negedge clk);
    check("stopi_flags", {30'b0, found_a, exhausted_a}, 32'b01);
    check("stopi_key", {8'b0, ifa.key}, 32'h2);
    check("stopi_acks", ack_cnt_a - ack_base, 32'd3);
    check("stopi_launches", key_log_a.size() - log_base, 32'd3);
    $display("scenario stop_invalid: key=%0h acks=%0d", ifa.key, ack_cnt_a - ack_base);

    // Same with a valid verdict on key 2: still found.
    valid_key_a = 24'h000002;
    log_base = key_log_a.size();
    start_a_pulse("stopv");
    wait_launch_a("stopv", log_base + 3);
    stop_a = 1'b1;
    repeat (2) @(negedge clk);
    stop_a = 1'b0;
    wait_idle_a("stopv");
    check("stopv_flags", {30'b0, found_a, exhausted_a}, 32'b10);
    check("stopv_key", {8'b0, ifa.key}, 32'h2);
    check("stopv_keys_tried", {8'b0, keys_tried_a}, 32'd3);
    $display("scenario stop_valid: key=%0h found=%0b", ifa.key, found_a);

    // Reset mid-search, then a clean restart.
    valid_key_a = 24'hFFFFFF;
    log_base = key_log_a.size();
    start_a_pulse("rst");
    wait_launch_a("rst", log_base + 2);
    repeat (2) @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    check("mid_rst_key", {8'b0, ifa.key}, 32'h0);
    check("mid_rst_keys_tried", {8'b0, keys_tried_a}, 32'h0);
    check("mid_rst_flags", {27'b0, found_a, exhausted_a, busy_a, ifa.test_start, ifa.crack_ack}, 32'h0);
    nreset = 1'b1;
    @(negedge clk);
    log_base = key_log_a.size();
    start_a_pulse("restart");
    @(negedge clk);
    check("restart_single_pulse", {31'b0, ifa.test_start}, 32'd0);
    check("restart_launch_count", key_log_a.size() - log_base, 32'd1);
    wait_idle_a("restart");
    check("restart_keys_tried", {8'b0, keys_tried_a}, 32'd6);
    check("no_overlap_launch", {31'b0, overlap_a}, 32'd0);
    $display("scenario reset_restart: tried=%0d", keys_tried_a);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
